// File: rtl/swar_playback_ctrl.sv
// swar_playback_ctrl: key-triggered swar sample sequencer feeding a registered PCM sample stream
module swar_playback_ctrl #(
    parameter int SAMPLE_DIV  = 6250,
    parameter int NUM_SAMPLES = 8000,
    parameter int NUM_SWARS   = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SWARS-1:0] key_in,
    input  logic [7:0]           mem_data,
    output logic [12:0]          address,
    output logic [2:0]           swar_select,
    output logic [7:0]           sample_out,
    output logic                 sample_valid,
    output logic                 busy
);
    typedef enum logic {IDLE, PLAY} state_t;
    state_t               state_q, state_d;
    logic [NUM_SWARS-1:0] sync1_q, sync2_q, prev_q, key_edge;
    logic [2:0]           swar_q, swar_d, edge_idx;
    logic [12:0]          addr_q, addr_d;
    logic [15:0]          tick_q, tick_d;
    logic [7:0]           sample_q, sample_d;
    logic                 valid_q, valid_d;
    logic                 tick, any_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            state_q  <= IDLE;
            swar_q   <= '0;
            addr_q   <= '0;
            tick_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            sync1_q  <= key_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            state_q  <= state_d;
            swar_q   <= swar_d;
            addr_q   <= addr_d;
            tick_q   <= tick_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    // Lowest-index rising edge wins when several keys go down together
    always_comb begin
        key_edge = sync2_q & ~prev_q;
        any_edge = |key_edge;
        edge_idx = '0;
        for (int i = NUM_SWARS - 1; i >= 0; i--)
            if (key_edge[i]) edge_idx = 3'(i);
    end

    always_comb begin
        state_d  = state_q;
        swar_d   = swar_q;
        addr_d   = addr_q;
        tick_d   = tick_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        tick     = tick_q == 16'(SAMPLE_DIV - 1);
        if (any_edge) begin
            state_d = PLAY;
            swar_d  = edge_idx;
            addr_d  = '0;
            tick_d  = '0;
        end else if (state_q == PLAY) begin
            tick_d = tick ? 16'd0 : tick_q + 16'd1;
            if (tick) begin
                if (!sync2_q[swar_q]) begin
                    state_d  = IDLE;
                    addr_d   = '0;
                    sample_d = 8'h00;
                end else begin
                    sample_d = mem_data;
                    valid_d  = 1'b1;
                    addr_d   = (addr_q == 13'(NUM_SAMPLES - 1)) ? 13'd0 : addr_q + 13'd1;
                    state_d  = (addr_q == 13'(NUM_SAMPLES - 1)) ? IDLE : PLAY;
                end
            end
        end
    end

    assign address      = addr_q;
    assign swar_select  = (state_q == PLAY) ? swar_q : 3'b111;
    assign busy         = state_q == PLAY;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
endmodule

// File: tb/tb_swar_playback_ctrl.sv
// tb_swar_playback_ctrl: randomized and directed checks of swar_playback_ctrl against an expected-sample model
module tb_swar_playback_ctrl;
    localparam int SD = 4;
    localparam int NS = 8;

    logic        clk, rst_n;
    logic [6:0]  key_in;
    logic [7:0]  mem_data;
    logic [12:0] address;
    logic [2:0]  swar_select;
    logic [7:0]  sample_out;
    logic        sample_valid, busy;
    int checks = 0;
    int errors = 0;

    swar_playback_ctrl #(.SAMPLE_DIV(SD), .NUM_SAMPLES(NS), .NUM_SWARS(7)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .mem_data(mem_data),
        .address(address), .swar_select(swar_select), .sample_out(sample_out),
        .sample_valid(sample_valid), .busy(busy)
    );

    // Memory model: byte = {swar, low five address bits}
    assign mem_data = {swar_select, address[4:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < limit);
    endtask

    task automatic wait_busy(input logic level, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== level && n < 20);
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        key_in = '0;
        repeat (2) @(negedge clk);
        checks++; if (address !== 13'd0) begin errors++; $display("FAIL reset_address: got %0h expected 0", address); end
        checks++; if (swar_select !== 3'b111) begin errors++; $display("FAIL reset_swar_select: got %0h expected 7", swar_select); end
        checks++; if (sample_out !== 8'h00) begin errors++; $display("FAIL reset_sample_out: got %0h expected 0", sample_out); end
        checks++; if ({busy, sample_valid} !== 2'b00) begin errors++; $display("FAIL reset_busy_valid: got %b expected 00", {busy, sample_valid}); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Press key k and release right after the m-th sample (or after the natural end)
    task automatic test_play(input int k, input int m);
        int n, np, cnt;
        logic [7:0] exp;
        np  = (m < NS) ? m : NS;
        exp = 8'h00;
        key_in[k] = 1'b1;
        wait_busy(1'b1, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL entry_latency k=%0d: got %0d expected 3", k, n); end
        checks++; if (swar_select !== 3'(k)) begin errors++; $display("FAIL play_swar_select: got %0d expected %0d", swar_select, k); end
        for (int p = 0; p < np; p++) begin
            wait_valid(10, n);
            exp = {3'(k), 5'(p)};
            checks++; if (n !== SD) begin errors++; $display("FAIL pulse_gap k=%0d p=%0d: got %0d expected %0d", k, p, n, SD); end
            checks++; if (sample_out !== exp) begin errors++; $display("FAIL sample k=%0d p=%0d: got %0h expected %0h", k, p, sample_out, exp); end
        end
        if (m < NS) begin
            key_in[k] = 1'b0;
            cnt = 0;
            repeat (8) begin @(negedge clk); if (sample_valid) cnt++; end
            checks++; if (cnt !== 0) begin errors++; $display("FAIL release_extra_pulse: got %0d expected 0", cnt); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy: got %b expected 0", busy); end
            checks++; if (sample_out !== 8'h00) begin errors++; $display("FAIL release_sample_out: got %0h expected 0", sample_out); end
        end else begin
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL end_busy: got %b expected 0", busy); end
            checks++; if (swar_select !== 3'b111) begin errors++; $display("FAIL end_swar_select: got %0h expected 7", swar_select); end
            checks++; if (address !== 13'd0) begin errors++; $display("FAIL end_address: got %0h expected 0", address); end
            cnt = 0;
            repeat (12) begin @(negedge clk); if (sample_valid || busy) cnt++; end
            checks++; if (cnt !== 0) begin errors++; $display("FAIL held_replay: got %0d active cycles expected 0", cnt); end
            checks++; if (sample_out !== exp) begin errors++; $display("FAIL end_hold_sample: got %0h expected %0h", sample_out, exp); end
            key_in[k] = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_retrigger;
        int n;
        key_in[1] = 1'b1;
        wait_busy(1'b1, n);
        for (int p = 0; p < 3; p++) wait_valid(10, n);
        checks++; if (address !== 13'd3) begin errors++; $display("FAIL retrig_addr_before: got %0d expected 3", address); end
        key_in[4] = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (address !== 13'd0) begin errors++; $display("FAIL retrig_address: got %0d expected 0", address); end
        checks++; if (swar_select !== 3'd4) begin errors++; $display("FAIL retrig_swar_select: got %0d expected 4", swar_select); end
        wait_valid(10, n);
        checks++; if (n !== SD) begin errors++; $display("FAIL retrig_latency: got %0d expected %0d", n, SD); end
        checks++; if (sample_out !== 8'h80) begin errors++; $display("FAIL retrig_sample: got %0h expected 80", sample_out); end
        key_in[1] = 1'b0;
        key_in[4] = 1'b0;
        wait_busy(1'b0, n);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL retrig_idle: got %b expected 0", busy); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_simultaneous;
        int n;
        key_in[3] = 1'b1;
        key_in[6] = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL simul_busy: got %b expected 1", busy); end
        checks++; if (swar_select !== 3'd3) begin errors++; $display("FAIL simul_priority: got %0d expected 3", swar_select); end
        key_in[3] = 1'b0;
        key_in[6] = 1'b0;
        wait_busy(1'b0, n);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_idle: got %b expected 0", busy); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        key_in[0] = 1'b1;
        wait_busy(1'b1, n);
        for (int p = 0; p < 5; p++) wait_valid(10, n);
        checks++; if (address !== 13'd5) begin errors++; $display("FAIL rmid_addr_before: got %0d expected 5", address); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (address !== 13'd0) begin errors++; $display("FAIL rmid_address: got %0d expected 0", address); end
        checks++; if (swar_select !== 3'b111) begin errors++; $display("FAIL rmid_swar_select: got %0h expected 7", swar_select); end
        checks++; if ({busy, sample_valid, sample_out} !== 10'd0) begin errors++; $display("FAIL rmid_outputs: got %b/%b/%0h expected 0/0/0", busy, sample_valid, sample_out); end
        key_in[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        key_in[6] = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({busy, swar_select, address} !== {1'b1, 3'd6, 13'd0}) begin errors++; $display("FAIL rmid_restart: got %b/%0d/%0d expected 1/6/0", busy, swar_select, address); end
        wait_valid(10, n);
        checks++; if (sample_out !== 8'hC0 || n !== SD) begin errors++; $display("FAIL rmid_first_sample: got %0h after %0d expected c0 after %0d", sample_out, n, SD); end
        key_in[6] = 1'b0;
        wait_busy(1'b0, n);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_play(2, NS);
        test_play(5, 3);
        test_retrigger;
        test_simultaneous;
        test_reset_mid;
        for (int r = 0; r < 8; r++) test_play(int'($urandom_range(0, 6)), int'($urandom_range(1, 10)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
